// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave front end.
// State, command encodings and widths used across the SPI-to-RAM path.
package spi_pkg;

  localparam int DATA_W = 8;
  localparam int CMD_W  = DATA_W + 2;
  localparam int CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  function automatic logic [CMD_W-1:0] shift_in(
    input logic [CMD_W-1:0] w,
    input logic             b
  );
    return {w[CMD_W-2:0], b};
  endfunction

endpackage

// File: rtl/spi_slave.sv
// spi_slave: MOSI/SS_n framed command words to RAM, RAM read data to MISO.
// Serial clock and system clock are the same clk.
import spi_pkg::*;

module spi_slave (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [CMD_W-1:0]  rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] RX_FULL = CNT_W'(CMD_W);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] TX_DONE = CNT_W'(DATA_W + 1);

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   tx_cnt;
  logic [CMD_W-1:0]   rx_sr;
  logic [DATA_W-1:0]  tx_sr;
  logic               rd_addr_seen;

  // Frame FSM: word assembly, read-address tracking and MISO serialiser.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      tx_cnt       <= '0;
      rx_sr        <= '0;
      tx_sr        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      MISO         <= 1'b0;
      rd_addr_seen <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        state   <= IDLE;
        bit_cnt <= '0;
        tx_cnt  <= '0;
        MISO    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state   <= CHK_CMD;
            bit_cnt <= '0;
            tx_cnt  <= '0;
          end
          CHK_CMD: begin
            rx_sr   <= {{(CMD_W-1){1'b0}}, MOSI};
            bit_cnt <= CNT_W'(1);
            if (!MOSI)
              state <= WRITE;
            else if (rd_addr_seen)
              state <= READ_DATA;
            else
              state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (bit_cnt < RX_FULL) begin
              rx_sr   <= shift_in(rx_sr, MOSI);
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == RX_LAST) begin
                rx_data  <= shift_in(rx_sr, MOSI);
                rx_valid <= 1'b1;
                if (state == READ_ADD)
                  rd_addr_seen <= 1'b1;
                if (state == READ_DATA)
                  rd_addr_seen <= 1'b0;
              end
            end else if (state == READ_DATA) begin
              if (tx_cnt == '0) begin
                if (tx_valid) begin
                  MISO   <= tx_data[DATA_W-1];
                  tx_sr  <= {tx_data[DATA_W-2:0], 1'b0};
                  tx_cnt <= CNT_W'(1);
                end
              end else if (tx_cnt < TX_LAST) begin
                MISO   <= tx_sr[DATA_W-1];
                tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
                tx_cnt <= tx_cnt + CNT_W'(1);
              end else begin
                MISO   <= 1'b0;
                tx_cnt <= TX_DONE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: table vectors plus random frames against a frame-level model.
// Model tracks the read-address flag and the expected MISO byte per frame.
import spi_pkg::*;

module tb_spi_slave;

  logic              clk;
  logic              rst_n;
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [CMD_W-1:0]  rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;

  int errors = 0;
  int checks = 0;
  bit m_flag = 1'b0;

  spi_slave dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] word;
    int         nbits;
    logic [7:0] txd;
    bit         give_tx;
    bit         exp_flag;
  } vec_t;

  vec_t tbl [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic frame(input logic [9:0] w, input int nb,
                       input logic [7:0] txd, input bit gtx);
    state_t es;
    bit rd;
    SS_n = 1'b0;
    MOSI = 1'($urandom);
    step();
    chk("state_e0", 32'(dut.state), 32'(CHK_CMD));
    for (int i = 0; i < nb; i++) begin
      MOSI = w[9-i];
      step();
      if (i == 0) begin
        if (!w[9]) es = WRITE;
        else if (m_flag) es = READ_DATA;
        else es = READ_ADD;
        chk("state_e1", 32'(dut.state), 32'(es));
      end
      if (i == 9) begin
        chk("rx_valid_e10", 32'(rx_valid), 32'd1);
        chk("rx_data", 32'(rx_data), 32'(w));
      end else begin
        chk("rx_valid_early", 32'(rx_valid), 32'd0);
      end
    end
    if (nb >= 10) begin
      rd = w[9] && m_flag;
      if (w[9]) m_flag = !m_flag;
      MOSI = 1'($urandom);
      step();
      chk("rx_valid_e11", 32'(rx_valid), 32'd0);
      if (gtx) begin
        tx_valid = 1'b1;
        tx_data  = txd;
      end
      step();
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      if (rd && gtx) begin
        chk("miso_b7", 32'(MISO), 32'(txd[7]));
        for (int k = 6; k >= 0; k--) begin
          step();
          chk("miso_bit", 32'(MISO), 32'(txd[k]));
        end
        step();
        chk("miso_tail", 32'(MISO), 32'd0);
      end else begin
        chk("miso_quiet", 32'(MISO), 32'd0);
      end
    end else if (nb >= 0) begin
      MOSI = w[9-nb];
    end
    SS_n = 1'b1;
    step();
    chk("state_end", 32'(dut.state), 32'(IDLE));
    chk("miso_end", 32'(MISO), 32'd0);
    chk("rx_valid_end", 32'(rx_valid), 32'd0);
    chk("flag_end", 32'(dut.rd_addr_seen), 32'(m_flag));
  endtask

  initial begin
    tbl[0] = '{10'h005, 10, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{10'h1AA, 10, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{10'h205, 10, 8'h00, 1'b0, 1'b1};
    tbl[3] = '{10'h3FF, 10, 8'hA5, 1'b1, 1'b0};
    tbl[4] = '{10'h205,  6, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{10'h205, 10, 8'h00, 1'b0, 1'b1};
    tbl[6] = '{10'h300,  6, 8'h00, 1'b0, 1'b1};
    tbl[7] = '{10'h055,  9, 8'h00, 1'b0, 1'b1};
    tbl[8] = '{10'h312, 10, 8'h3C, 1'b1, 1'b0};
    tbl[9] = '{10'h0F0, 10, 8'hFF, 1'b1, 1'b0};

    rst_n    = 1'b0;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    step();
    step();
    chk("rst_miso", 32'(MISO), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_flag", 32'(dut.rd_addr_seen), 32'd0);
    rst_n = 1'b1;
    step();

    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_spurious_tx", 32'(MISO), 32'd0);
    end
    tx_valid = 1'b0;

    for (int i = 0; i < 10; i++) begin
      frame(tbl[i].word, tbl[i].nbits, tbl[i].txd, tbl[i].give_tx);
      chk("tbl_flag", 32'(dut.rd_addr_seen), 32'(tbl[i].exp_flag));
    end

    frame(10'h2AB, 10, 8'h00, 1'b0);
    SS_n = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      MOSI = (i < 2) ? 1'b1 : 1'($urandom);
      step();
    end
    step();
    tx_valid = 1'b1;
    tx_data  = 8'h96;
    step();
    tx_valid = 1'b0;
    chk("rrst_b7", 32'(MISO), 32'd1);
    step();
    chk("rrst_b6", 32'(MISO), 32'd0);
    step();
    chk("rrst_b5", 32'(MISO), 32'd0);
    rst_n = 1'b0;
    SS_n  = 1'b1;
    step();
    chk("mrst_miso", 32'(MISO), 32'd0);
    chk("mrst_rx_data", 32'(rx_data), 32'd0);
    chk("mrst_rx_valid", 32'(rx_valid), 32'd0);
    chk("mrst_state", 32'(dut.state), 32'(IDLE));
    chk("mrst_flag", 32'(dut.rd_addr_seen), 32'd0);
    rst_n  = 1'b1;
    m_flag = 1'b0;
    step();
    frame(10'h2F0, 10, 8'h00, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [9:0] w;
      int nb;
      w  = 10'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : 10;
      frame(w, nb, 8'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

Serial front end of the SPI-to-RAM path: converts MOSI bit stream framed by SS_n into 10-bit command words for the single-port RAM, and serialises the RAM's 8-bit read data back onto MISO. It sits directly upstream of the RAM (drives its din/rx_valid) and consumes the RAM's dout/tx_valid. Serial clock and system clock are the same clk.

## Interface
- DATA_W, 8, RAM data/address width
- CMD_W, 10, command word width (DATA_W + 2 command bits)

- clk  in  1  clock; MOSI sampled, MISO updated on rising edge
- rst_n  in  1  reset, synchronous, active-low
- SS_n  in  1  slave select, active-low frame
- MOSI  in  1  serial in, MSB first
- MISO  out  1  serial out, MSB first
- rx_data  out  CMD_W  assembled word to RAM din
- rx_valid  out  1  one-cycle strobe, rx_data valid
- tx_data  in  DATA_W  RAM read data
- tx_valid  in  1  RAM read data valid strobe

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 sampled -> CHK_CMD; MOSI ignored.
- CHK_CMD: captures MOSI as word bit 9 (count=1); MOSI=0 -> WRITE; MOSI=1 -> READ_ADD if rd_addr_seen=0, else READ_DATA.
- WRITE/READ_ADD/READ_DATA: shift in remaining 9 bits (bits 8..0); on 10th captured bit, rx_data <= full word, rx_valid <= 1 for exactly one cycle.
- rx_data passed verbatim; bit 8 not interpreted by this block.
- rd_addr_seen: set when a READ_ADD word completes; cleared when a READ_DATA word completes; cleared on reset; unchanged by aborted frames.
- READ_DATA after word complete: wait for tx_valid; on edge sampling tx_valid=1, load tx shift register, MISO = bit 7; next 7 edges shift out bits 6..0; then MISO=0, stay in READ_DATA until SS_n=1.
- tx_valid outside READ_DATA wait phase: ignored.
- SS_n=1 sampled in any state -> IDLE next cycle; counters cleared; MISO=0; partial word discarded, no rx_valid.
- Reset values: MISO=0, rx_data=0, rx_valid=0, state IDLE, rd_addr_seen=0, counters 0.

## Timing
- Edge E0: SS_n=0 sampled in IDLE. E1..E10: MOSI bits 9..0 sampled.
- rx_valid high in cycle after E10, low after E11.
- RAM returns tx_valid high after E11; slave samples it at E12; MISO bit 7 valid after E12, bit 0 after E19.
- Minimum frames with SS_n low: write/read-address 11 edges (E0..E10, SS_n high sampled at E11 or later); read-data 20 edges.
- Back-to-back frames: SS_n high for one edge sufficient; next frame begins at following SS_n=0 edge.
- SS_n rising in same edge as 10th bit: bit is not captured (SS_n check has priority), no rx_valid.

## Structure
- Shared package spi_pkg: state enum, CMD_W/DATA_W constants, bit-count width (4 bits), command encodings (00 wr addr, 01 wr data, 10 rd addr, 11 rd data).
- Single module; no sub-module. Top-level wrapper spi_slave + ram instantiated separately.

## Test plan
- Write addr: SS_n low, MOSI 00_0000_0101 -> rx_data=0x005, one rx_valid pulse after E10, state IDLE after SS_n high.
- Write data: MOSI 01_1010_1010 -> rx_data=0x1AA; rd_addr_seen stays 0.
- Read sequence: MOSI 10_0000_0101 (state READ_ADD, flag set), then 11_xxxx_xxxx with tx_valid+tx_data=0xA5 after E11 -> MISO 1,0,1,0,0,1,0,1 after E12..E19; flag cleared.
- Abort: SS_n high after 6 bits -> no rx_valid, IDLE, rd_addr_seen unchanged; next full frame decodes correctly.
- Reset mid-read-data (after E14): all outputs 0, IDLE, flag 0; next MOSI=1 frame goes READ_ADD.
- Spurious tx_valid=1 in IDLE/WRITE -> MISO stays 0.
